fp_sign_pipe: RTL and testbench

FP_SIGN_PIPE -- requirements
Module: fp_sign_pipe

---
 rtl/fp_sign_pkg.sv | 22 ++
 rtl/fp_sign_pipe_if.sv | 39 +++
 rtl/fp_mag_compare.sv | 37 +++
 rtl/fp_sign_pipe.sv | 167 ++++++++++++++++
 tb/tb_fp_sign_pipe.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_sign_pkg.sv
// Shared types and constants for the floating-point sign-resolution pipeline.
package fp_sign_pkg;

  localparam int unsigned RND_W = 2;

  localparam logic ADD = 1'b1;
  localparam logic SUB = 1'b0;

  typedef enum logic [RND_W-1:0] {
    RNE = 2'd0,
    RTZ = 2'd1,
    RDN = 2'd2,
    RUP = 2'd3
  } rnd_mode_t;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } mag_cmp_t;

endpackage

// File: rtl/fp_sign_pipe_if.sv
// Operand/result handshake bundle for fp_sign_pipe; slave is the pipeline side.
interface fp_sign_pipe_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
);
  import fp_sign_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic             a_sign;
  logic [EXP_W-1:0] a_exp;
  logic [MAN_W-1:0] a_frac;
  logic             b_sign;
  logic [EXP_W-1:0] b_exp;
  logic [MAN_W-1:0] b_frac;
  logic             operation;
  rnd_mode_t        rnd_mode;

  logic             out_valid;
  logic             out_ready;
  logic             sign_result;
  logic             eff_sub;
  logic             swap;
  logic [EXP_W-1:0] exp_diff;
  logic             is_nan;

  modport slave (
    input  in_valid, a_sign, a_exp, a_frac, b_sign, b_exp, b_frac, operation, rnd_mode,
    input  out_ready,
    output in_ready, out_valid, sign_result, eff_sub, swap, exp_diff, is_nan
  );

  modport master (
    output in_valid, a_sign, a_exp, a_frac, b_sign, b_exp, b_frac, operation, rnd_mode,
    output out_ready,
    input  in_ready, out_valid, sign_result, eff_sub, swap, exp_diff, is_nan
  );

endinterface

// File: rtl/fp_mag_compare.sv
// Combinational magnitude compare of {exp,frac} and absolute exponent difference.
module fp_mag_compare
  import fp_sign_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic [EXP_W-1:0] a_exp,
  input  logic [MAN_W-1:0] a_frac,
  input  logic [EXP_W-1:0] b_exp,
  input  logic [MAN_W-1:0] b_frac,
  output mag_cmp_t         cmp_c,
  output logic [EXP_W-1:0] exp_diff_c
);

  localparam int unsigned MAG_W  = EXP_W + MAN_W;
  localparam int unsigned DIFF_W = EXP_W + 1;

  logic [MAG_W-1:0]  a_mag;
  logic [MAG_W-1:0]  b_mag;
  logic [DIFF_W-1:0] diff_raw;
  logic [DIFF_W-1:0] diff_abs;

  always_comb begin
    a_mag    = {a_exp, a_frac};
    b_mag    = {b_exp, b_frac};
    cmp_c    = '0;
    cmp_c.gt = (a_mag > b_mag);
    cmp_c.lt = (a_mag < b_mag);
    cmp_c.eq = (a_mag == b_mag);
    // Extra bit carries the borrow so the sign of a_exp - b_exp is known.
    diff_raw   = DIFF_W'(a_exp) - DIFF_W'(b_exp);
    diff_abs   = diff_raw[EXP_W] ? (~diff_raw + DIFF_W'(1)) : diff_raw;
    exp_diff_c = EXP_W'(diff_abs);
  end

endmodule

// File: rtl/fp_sign_pipe.sv
// Two-stage valid/ready pipeline resolving effective operation and result sign of an FP add/sub.
// Define FP_SIGN_SPECIAL_EN to flag NaN operands and Inf-Inf as invalid (is_nan=1, sign forced 0).
module fp_sign_pipe
  import fp_sign_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic           clk,
  input  logic           n_rst,
  fp_sign_pipe_if.slave  bus
);

  mag_cmp_t         cmp_c;
  logic [EXP_W-1:0] exp_diff_c;
  logic             eff_sub_c;
  logic             nan_c;
  logic             sign_res_c;
  logic             s1_ready_c;
  logic             s2_ready_c;

  logic             s1_valid_q,    s1_valid_d;
  mag_cmp_t         s1_cmp_q,      s1_cmp_d;
  logic             s1_eff_sub_q,  s1_eff_sub_d;
  logic [EXP_W-1:0] s1_exp_diff_q, s1_exp_diff_d;
  logic             s1_a_sign_q,   s1_a_sign_d;
  logic             s1_b_sign_q,   s1_b_sign_d;
  logic             s1_op_q,       s1_op_d;
  rnd_mode_t        s1_rnd_q,      s1_rnd_d;
  logic             s1_nan_q,      s1_nan_d;

  logic             s2_valid_q,    s2_valid_d;
  logic             s2_sign_q,     s2_sign_d;
  logic             s2_eff_sub_q,  s2_eff_sub_d;
  logic             s2_swap_q,     s2_swap_d;
  logic [EXP_W-1:0] s2_exp_diff_q, s2_exp_diff_d;
  logic             s2_nan_q,      s2_nan_d;

  fp_mag_compare #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_mag_compare (
    .a_exp      (bus.a_exp),
    .a_frac     (bus.a_frac),
    .b_exp      (bus.b_exp),
    .b_frac     (bus.b_frac),
    .cmp_c      (cmp_c),
    .exp_diff_c (exp_diff_c)
  );

  // Stage readiness depends only on registered valids and out_ready.
  assign s2_ready_c   = !s2_valid_q || bus.out_ready;
  assign s1_ready_c   = !s1_valid_q || s2_ready_c;
  assign bus.in_ready = s1_ready_c;

  always_comb begin
    eff_sub_c = bus.a_sign ^ bus.b_sign ^ ~bus.operation;
    nan_c     = 1'b0;
`ifdef FP_SIGN_SPECIAL_EN
    nan_c = ((&bus.a_exp) && (|bus.a_frac))
         || ((&bus.b_exp) && (|bus.b_frac))
         || ((&bus.a_exp) && ~(|bus.a_frac) && (&bus.b_exp) && ~(|bus.b_frac) && eff_sub_c);
`endif
  end

  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_cmp_d      = s1_cmp_q;
    s1_eff_sub_d  = s1_eff_sub_q;
    s1_exp_diff_d = s1_exp_diff_q;
    s1_a_sign_d   = s1_a_sign_q;
    s1_b_sign_d   = s1_b_sign_q;
    s1_op_d       = s1_op_q;
    s1_rnd_d      = s1_rnd_q;
    s1_nan_d      = s1_nan_q;
    if (s1_ready_c) begin
      s1_valid_d = bus.in_valid;
    end
    if (s1_ready_c && bus.in_valid) begin
      s1_cmp_d      = cmp_c;
      s1_eff_sub_d  = eff_sub_c;
      s1_exp_diff_d = exp_diff_c;
      s1_a_sign_d   = bus.a_sign;
      s1_b_sign_d   = bus.b_sign;
      s1_op_d       = bus.operation;
      s1_rnd_d      = bus.rnd_mode;
      s1_nan_d      = nan_c;
    end
  end

  // Sign of the result; an exact cancellation takes its sign from the rounding mode.
  always_comb begin
    sign_res_c = s1_a_sign_q;
    if (s1_nan_q) begin
      sign_res_c = 1'b0;
    end else if (s1_eff_sub_q) begin
      if (s1_cmp_q.lt) begin
        sign_res_c = s1_b_sign_q ^ ~s1_op_q;
      end else if (s1_cmp_q.eq) begin
        sign_res_c = (s1_rnd_q == RDN);
      end
    end
  end

  always_comb begin
    s2_valid_d    = s2_valid_q;
    s2_sign_d     = s2_sign_q;
    s2_eff_sub_d  = s2_eff_sub_q;
    s2_swap_d     = s2_swap_q;
    s2_exp_diff_d = s2_exp_diff_q;
    s2_nan_d      = s2_nan_q;
    if (s2_ready_c) begin
      s2_valid_d = s1_valid_q;
    end
    if (s2_ready_c && s1_valid_q) begin
      s2_sign_d     = sign_res_c;
      s2_eff_sub_d  = s1_eff_sub_q;
      s2_swap_d     = s1_cmp_q.lt;
      s2_exp_diff_d = s1_exp_diff_q;
      s2_nan_d      = s1_nan_q;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1_valid_q    <= 1'b0;
      s1_cmp_q      <= '0;
      s1_eff_sub_q  <= 1'b0;
      s1_exp_diff_q <= '0;
      s1_a_sign_q   <= 1'b0;
      s1_b_sign_q   <= 1'b0;
      s1_op_q       <= 1'b0;
      s1_rnd_q      <= RNE;
      s1_nan_q      <= 1'b0;
      s2_valid_q    <= 1'b0;
      s2_sign_q     <= 1'b0;
      s2_eff_sub_q  <= 1'b0;
      s2_swap_q     <= 1'b0;
      s2_exp_diff_q <= '0;
      s2_nan_q      <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_cmp_q      <= s1_cmp_d;
      s1_eff_sub_q  <= s1_eff_sub_d;
      s1_exp_diff_q <= s1_exp_diff_d;
      s1_a_sign_q   <= s1_a_sign_d;
      s1_b_sign_q   <= s1_b_sign_d;
      s1_op_q       <= s1_op_d;
      s1_rnd_q      <= s1_rnd_d;
      s1_nan_q      <= s1_nan_d;
      s2_valid_q    <= s2_valid_d;
      s2_sign_q     <= s2_sign_d;
      s2_eff_sub_q  <= s2_eff_sub_d;
      s2_swap_q     <= s2_swap_d;
      s2_exp_diff_q <= s2_exp_diff_d;
      s2_nan_q      <= s2_nan_d;
    end
  end

  assign bus.out_valid   = s2_valid_q;
  assign bus.sign_result = s2_sign_q;
  assign bus.eff_sub     = s2_eff_sub_q;
  assign bus.swap        = s2_swap_q;
  assign bus.exp_diff    = s2_exp_diff_q;
  assign bus.is_nan      = s2_nan_q;

endmodule

// File: tb/tb_fp_sign_pipe.sv
// Scoreboard bench for fp_sign_pipe (EXP_W=8, MAN_W=23); expectations pushed on accept, popped on drain.
module tb_fp_sign_pipe;
  import fp_sign_pkg::*;

  typedef struct packed {
    logic        a_s;
    logic [7:0]  ae;
    logic [22:0] af;
    logic        b_s;
    logic [7:0]  be;
    logic [22:0] bf;
    logic        op;
    rnd_mode_t   rm;
  } stim_t;

  typedef struct packed {
    logic       sign;
    logic       eff_sub;
    logic       swap;
    logic [7:0] exp_diff;
    logic       nan;
  } res_t;

  logic clk = 1'b0;
  logic n_rst;
  int   total = 0;
  int   bad   = 0;

  stim_t stim_q[$];
  res_t  sb_q[$];
  res_t  got_q[$];
  res_t  snap_q[$];
  logic  rdy_q[$];
  logic  vld_q[$];

  fp_sign_pipe_if #(.EXP_W(8), .MAN_W(23)) bus ();

  fp_sign_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic stim_t mk(logic a_s, logic [7:0] ae, logic [22:0] af,
                               logic b_s, logic [7:0] be, logic [22:0] bf,
                               logic op, rnd_mode_t rm);
    stim_t s;
    s.a_s = a_s; s.ae = ae; s.af = af;
    s.b_s = b_s; s.be = be; s.bf = bf;
    s.op = op; s.rm = rm;
    return s;
  endfunction

  function automatic res_t model(stim_t s);
    res_t        r;
    logic [30:0] ma;
    logic [30:0] mb;
    ma = {s.ae, s.af};
    mb = {s.be, s.bf};
    r.eff_sub  = s.a_s ^ s.b_s ^ ~s.op;
    r.swap     = (ma < mb);
    r.exp_diff = (s.ae >= s.be) ? (s.ae - s.be) : (s.be - s.ae);
    if (!r.eff_sub || ma > mb) r.sign = s.a_s;
    else if (ma < mb)          r.sign = s.b_s ^ ~s.op;
    else                       r.sign = (s.rm == RDN);
    r.nan = 1'b0;
`ifdef FP_SIGN_SPECIAL_EN
    if ((s.ae == 8'hFF && s.af != 0) || (s.be == 8'hFF && s.bf != 0) ||
        (s.ae == 8'hFF && s.af == 0 && s.be == 8'hFF && s.bf == 0 && r.eff_sub)) begin
      r.nan  = 1'b1;
      r.sign = 1'b0;
    end
`endif
    return r;
  endfunction

  task automatic drive(stim_t s);
    bus.in_valid  = 1'b1;
    bus.a_sign    = s.a_s; bus.a_exp = s.ae; bus.a_frac = s.af;
    bus.b_sign    = s.b_s; bus.b_exp = s.be; bus.b_frac = s.bf;
    bus.operation = s.op;  bus.rnd_mode = s.rm;
  endtask

  // One clock: sample handshakes before the edge, log accept into the scoreboard.
  task automatic cycle(output logic acc, output logic drn, output logic rdy,
                       output logic vld, output res_t g);
    stim_t s;
    #1;
    acc = bus.in_valid && bus.in_ready;
    drn = bus.out_valid && bus.out_ready;
    rdy = bus.in_ready;
    vld = bus.out_valid;
    g.sign = bus.sign_result; g.eff_sub = bus.eff_sub; g.swap = bus.swap;
    g.exp_diff = bus.exp_diff; g.nan = bus.is_nan;
    if (acc) begin
      s = mk(bus.a_sign, bus.a_exp, bus.a_frac, bus.b_sign, bus.b_exp, bus.b_frac,
             bus.operation, bus.rnd_mode);
      sb_q.push_back(model(s));
    end
    @(negedge clk);
  endtask

  task automatic run_stream(input int stall_from, input int stall_len, input bit rnd, input int budget);
    int   n;
    int   i;
    int   cyc;
    logic acc, drn, rdy, vld;
    res_t g;
    n = stim_q.size(); i = 0; cyc = 0;
    got_q.delete(); snap_q.delete(); rdy_q.delete(); vld_q.delete();
    while ((i < n || got_q.size() < n) && cyc < budget) begin
      if (rnd) bus.out_ready = ($urandom_range(0, 3) != 0);
      else     bus.out_ready = !(cyc >= stall_from && cyc < stall_from + stall_len);
      if (i < n && (!rnd || $urandom_range(0, 4) != 0)) drive(stim_q[i]);
      else bus.in_valid = 1'b0;
      cycle(acc, drn, rdy, vld, g);
      rdy_q.push_back(rdy); vld_q.push_back(vld); snap_q.push_back(g);
      if (acc) i++;
      if (drn) got_q.push_back(g);
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    stim_q.delete();
  endtask

  task automatic test_reset();
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    total++; if ({bus.sign_result, bus.eff_sub, bus.swap, bus.exp_diff, bus.is_nan} !== 12'h000) begin
      bad++; $display("FAIL reset_outputs got=%h exp=000", {bus.sign_result, bus.eff_sub, bus.swap, bus.exp_diff, bus.is_nan});
    end
    @(negedge clk);
  endtask

  task automatic test_latency();
    logic acc, drn, rdy, vld;
    res_t g;
    res_t e;
    int   lat;
    bus.out_ready = 1'b1;
    drive(mk(1'b0, 8'd127, 23'd0, 1'b0, 8'd128, 23'd0, SUB, RNE));
    cycle(acc, drn, rdy, vld, g);
    bus.in_valid = 1'b0;
    lat = 0; drn = 1'b0;
    while (!drn && lat < 10) begin
      lat++;
      cycle(acc, drn, rdy, vld, g);
    end
    total++; if (lat !== 2) begin bad++; $display("FAIL latency got=%0d exp=2", lat); end
    e = '{sign: 1'b1, eff_sub: 1'b1, swap: 1'b1, exp_diff: 8'd1, nan: 1'b0};
    total++; if (g !== e) begin bad++; $display("FAIL one_sub_two got=%h exp=%h", g, e); end
    if (sb_q.size() != 0) void'(sb_q.pop_front());
  endtask

  task automatic test_eq_cancel();
    stim_q.push_back(mk(1'b0, 8'd128, 23'h400000, 1'b0, 8'd128, 23'h400000, SUB, RDN));
    stim_q.push_back(mk(1'b0, 8'd128, 23'h400000, 1'b0, 8'd128, 23'h400000, SUB, RNE));
    stim_q.push_back(mk(1'b1, 8'd0, 23'd0, 1'b1, 8'd0, 23'd0, ADD, RNE));
    run_stream(0, 0, 1'b0, 40);
    total++; if (got_q.size() !== 3) begin bad++; $display("FAIL eq_count got=%0d exp=3", got_q.size()); end
    if (got_q.size() == 3) begin
      total++; if (got_q[0] !== 12'b1_1_0_00000000_0) begin bad++; $display("FAIL eq_rdn got=%h exp=%h", got_q[0], 12'b1_1_0_00000000_0); end
      total++; if (got_q[1] !== 12'b0_1_0_00000000_0) begin bad++; $display("FAIL eq_rne got=%h exp=%h", got_q[1], 12'b0_1_0_00000000_0); end
      total++; if (got_q[2] !== 12'b1_0_0_00000000_0) begin bad++; $display("FAIL negzero_add got=%h exp=%h", got_q[2], 12'b1_0_0_00000000_0); end
    end
    sb_q.delete();
  endtask

  task automatic test_back_to_back();
    stim_q.push_back(mk(1'b0, 8'd127, 23'd0, 1'b0, 8'd128, 23'd0, SUB, RNE));
    stim_q.push_back(mk(1'b0, 8'd0, 23'd5, 1'b1, 8'd255, 23'd0, ADD, RTZ));
    stim_q.push_back(mk(1'b1, 8'd255, 23'd0, 1'b0, 8'd0, 23'd0, SUB, RUP));
    stim_q.push_back(mk(1'b0, 8'd130, 23'd1, 1'b0, 8'd130, 23'd0, SUB, RDN));
    run_stream(1, 3, 1'b0, 60);
    total++; if (rdy_q.size() < 4 || rdy_q[2] !== 1'b0 || rdy_q[3] !== 1'b0) begin
      bad++; $display("FAIL b2b_in_ready_held got=%0d cycles exp=low at cycles 2,3", rdy_q.size());
    end
    total++; if (vld_q.size() < 4 || vld_q[3] !== 1'b1 || snap_q[3] !== sb_q[0]) begin
      bad++; $display("FAIL b2b_hold got=%h exp=%h", (snap_q.size() > 3) ? snap_q[3] : 12'h0, sb_q[0]);
    end
    total++; if (got_q.size() !== 4) begin bad++; $display("FAIL b2b_count got=%0d exp=4", got_q.size()); end
    if (got_q.size() == 4) begin
      total++; if ({got_q[1].swap, got_q[1].exp_diff} !== 9'h1FF) begin
        bad++; $display("FAIL b2b_diff_max_swap got=%h exp=1ff", {got_q[1].swap, got_q[1].exp_diff});
      end
      total++; if ({got_q[2].swap, got_q[2].exp_diff} !== 9'h0FF) begin
        bad++; $display("FAIL b2b_diff_max_noswap got=%h exp=0ff", {got_q[2].swap, got_q[2].exp_diff});
      end
      total++; if ({got_q[3].sign, got_q[3].swap, got_q[3].exp_diff} !== 10'h000) begin
        bad++; $display("FAIL b2b_frac_gt got=%h exp=000", {got_q[3].sign, got_q[3].swap, got_q[3].exp_diff});
      end
    end
    for (int k = 0; k < got_q.size(); k++) begin
      res_t e;
      e = (sb_q.size() != 0) ? sb_q.pop_front() : 12'hFFF;
      total++; if (got_q[k] !== e) begin bad++; $display("FAIL b2b_order[%0d] got=%h exp=%h", k, got_q[k], e); end
    end
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_no_dup got=%b exp=0", bus.out_valid); end
    @(negedge clk);
  endtask

  task automatic test_special();
    logic exp_nan;
    logic exp_sign;
`ifdef FP_SIGN_SPECIAL_EN
    exp_nan = 1'b1; exp_sign = 1'b0;
`else
    exp_nan = 1'b0; exp_sign = 1'b1;
`endif
    stim_q.push_back(mk(1'b0, 8'hFF, 23'd0, 1'b0, 8'hFF, 23'd0, SUB, RDN));
    stim_q.push_back(mk(1'b1, 8'hFF, 23'd3, 1'b0, 8'd127, 23'd0, ADD, RNE));
    run_stream(0, 0, 1'b0, 40);
    total++; if (got_q.size() !== 2) begin bad++; $display("FAIL special_count got=%0d exp=2", got_q.size()); end
    if (got_q.size() == 2) begin
      total++; if ({got_q[0].nan, got_q[0].sign} !== {exp_nan, exp_sign}) begin
        bad++; $display("FAIL inf_sub_inf got=%b%b exp=%b%b", got_q[0].nan, got_q[0].sign, exp_nan, exp_sign);
      end
      total++; if (got_q[1] !== sb_q[1]) begin bad++; $display("FAIL nan_operand got=%h exp=%h", got_q[1], sb_q[1]); end
    end
    sb_q.delete();
  endtask

  task automatic test_random();
    for (int k = 0; k < 24; k++) begin
      stim_q.push_back(mk(1'($urandom_range(0, 1)), 8'($urandom_range(125, 130)), 23'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 8'($urandom_range(125, 130)), 23'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), rnd_mode_t'(2'($urandom_range(0, 3)))));
    end
    run_stream(0, 0, 1'b1, 600);
    total++; if (got_q.size() !== 24) begin bad++; $display("FAIL rand_count got=%0d exp=24", got_q.size()); end
    for (int k = 0; k < got_q.size(); k++) begin
      res_t e;
      e = (sb_q.size() != 0) ? sb_q.pop_front() : 12'hFFF;
      total++; if (got_q[k] !== e) begin bad++; $display("FAIL rand[%0d] got=%h exp=%h", k, got_q[k], e); end
    end
    sb_q.delete();
  endtask

  task automatic test_reset_mid();
    logic acc, drn, rdy, vld;
    res_t g;
    int   seen;
    bus.out_ready = 1'b0;
    drive(mk(1'b0, 8'd127, 23'd0, 1'b0, 8'd128, 23'd0, SUB, RNE));
    cycle(acc, drn, rdy, vld, g);
    drive(mk(1'b1, 8'd129, 23'd7, 1'b0, 8'd128, 23'd0, ADD, RUP));
    cycle(acc, drn, rdy, vld, g);
    bus.in_valid = 1'b0;
    #1;
    total++; if ({bus.out_valid, bus.in_ready} !== 2'b10) begin
      bad++; $display("FAIL rst_mid_full got=%b%b exp=10", bus.out_valid, bus.in_ready);
    end
    n_rst = 1'b0;
    #1;
    total++; if ({bus.out_valid, bus.sign_result, bus.eff_sub, bus.swap, bus.exp_diff, bus.is_nan} !== 13'h0) begin
      bad++; $display("FAIL rst_mid_async got=%h exp=0", {bus.out_valid, bus.sign_result, bus.eff_sub, bus.swap, bus.exp_diff, bus.is_nan});
    end
    sb_q.delete();
    @(negedge clk);
    n_rst = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_in_ready got=%b exp=1", bus.in_ready); end
    bus.out_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      cycle(acc, drn, rdy, vld, g);
      if (vld) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rst_mid_stale got=%0d exp=0", seen); end
  endtask

  initial begin
    n_rst = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.a_sign = 1'b0; bus.a_exp = '0; bus.a_frac = '0;
    bus.b_sign = 1'b0; bus.b_exp = '0; bus.b_frac = '0;
    bus.operation = ADD; bus.rnd_mode = RNE;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    test_reset();
    test_latency();
    test_eq_cancel();
    test_back_to_back();
    test_special();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
